// File: rtl/morse_pkg.sv
// Shared state encoding and symbol constants for the Morse key decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } morse_state_t;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

endpackage

// File: rtl/morse_press_timer.sv
// Saturating up-counter with clear / load-one and a >= threshold compare.
// One instance times presses, inter-symbol gaps and the idle word gap.
module morse_press_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_one,
    input  logic             inc,
    input  logic [CNT_W-1:0] thresh,
    output logic             hit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load_one) begin
            count <= CNT_W'(1);
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

    assign hit = (count >= thresh);

endmodule

// File: rtl/morse_symbol_decoder.sv
// Times key presses/releases, classifies DOT/DASH and presents one letter via valid/ack.
// Optional idle word-gap pulse is built only when MORSE_WORD_GAP_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for first press of a letter (word-gap timing when enabled)
//  PRESS | key held, press length being timed
//  GAP   | key released, timing the gap that closes the letter
//  DONE  | letter presented on pattern/len, waiting for ack
module morse_symbol_decoder
    import morse_pkg::*;
#(
    parameter int DASH_CYCLES       = 8,
    parameter int LETTER_GAP_CYCLES = 16,
    parameter int WORD_GAP_CYCLES   = 40,
    parameter int MAX_SYMBOLS       = 5,
    parameter int CNT_W             = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               btn,
    input  logic                               ack,
    output logic                               valid,
    output logic [MAX_SYMBOLS-1:0]             pattern,
    output logic [$clog2(MAX_SYMBOLS+1)-1:0]   len,
    output logic                               overflow,
    output logic                               busy,
    output logic                               word_gap
);

    localparam int LEN_W = $clog2(MAX_SYMBOLS + 1);

    // Compare against N-1 because the counter already holds 1 on the first counted cycle.
    localparam logic [CNT_W-1:0] DASH_T = CNT_W'(DASH_CYCLES);
    localparam logic [CNT_W-1:0] GAP_T  = CNT_W'(LETTER_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_T = CNT_W'(WORD_GAP_CYCLES - 1);

    morse_state_t     state;
    logic             tmr_clear;
    logic             tmr_load;
    logic             tmr_inc;
    logic [CNT_W-1:0] tmr_thresh;
    logic             tmr_hit;
    logic             sym;
    logic             wg_armed;

    morse_press_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .load_one (tmr_load),
        .inc      (tmr_inc),
        .thresh   (tmr_thresh),
        .hit      (tmr_hit)
    );

    assign sym = tmr_hit ? SYM_DASH : SYM_DOT;

    always_comb begin
        tmr_clear  = 1'b0;
        tmr_load   = 1'b0;
        tmr_inc    = 1'b0;
        tmr_thresh = DASH_T;
        case (state)
            S_IDLE: begin
                tmr_thresh = WORD_T;
                if (btn) tmr_load = 1'b1;
                else     tmr_inc  = wg_armed;
            end
            S_PRESS: begin
                tmr_thresh = DASH_T;
                if (btn) tmr_inc  = 1'b1;
                else     tmr_load = 1'b1;
            end
            S_GAP: begin
                tmr_thresh = GAP_T;
                if (btn) tmr_load = 1'b1;
                else     tmr_inc  = 1'b1;
            end
            S_DONE: begin
                tmr_clear = ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            valid    <= 1'b0;
            pattern  <= '0;
            len      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (btn) begin
                        state <= S_PRESS;
                        busy  <= 1'b1;
                    end
                end
                S_PRESS: begin
                    if (!btn) begin
                        state <= S_GAP;
                        if (len == LEN_W'(MAX_SYMBOLS)) begin
                            overflow <= 1'b1;
                        end else begin
                            pattern <= pattern | (MAX_SYMBOLS'(sym) << len);
                            len     <= len + LEN_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (btn) begin
                        state <= S_PRESS;
                    end else if (tmr_hit) begin
                        state <= S_DONE;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        state    <= S_IDLE;
                        valid    <= 1'b0;
                        pattern  <= '0;
                        len      <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MORSE_WORD_GAP_EN
    // Armed by each ack; a press or the single pulse disarms until the next ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wg_armed <= 1'b0;
            word_gap <= 1'b0;
        end else begin
            word_gap <= 1'b0;
            if (state == S_DONE && ack) begin
                wg_armed <= 1'b1;
            end else if (state == S_IDLE && wg_armed) begin
                if (btn) begin
                    wg_armed <= 1'b0;
                end else if (tmr_hit) begin
                    word_gap <= 1'b1;
                    wg_armed <= 1'b0;
                end
            end
        end
    end
`else
    assign wg_armed = 1'b0;
    assign word_gap = 1'b0;
`endif

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Randomised scoreboard bench for morse_symbol_decoder: letters are modelled from press lengths.
module tb_morse_symbol_decoder;

    localparam int DASH = 8;
    localparam int LG   = 16;
    localparam int WG   = 40;
    localparam int MAXS = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic       ack;
    logic       valid;
    logic [4:0] pattern;
    logic [2:0] len;
    logic       overflow;
    logic       busy;
    logic       word_gap;

    int checks = 0;
    int failures = 0;
    int wg_pulses = 0;
    int wg_expected = 0;

    typedef struct {
        int pat;
        int ln;
        int ovf;
    } letter_t;

    letter_t exp_q[$];
    int      d[$];

    always #5 clk = ~clk;

    morse_symbol_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .ack      (ack),
        .valid    (valid),
        .pattern  (pattern),
        .len      (len),
        .overflow (overflow),
        .busy     (busy),
        .word_gap (word_gap)
    );

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: first MAXS presses become symbols, press >= DASH cycles is a dash.
    function automatic letter_t model(input int durs[$]);
        letter_t r;
        r.pat = 0;
        r.ln  = (durs.size() > MAXS) ? MAXS : durs.size();
        r.ovf = (durs.size() > MAXS) ? 1 : 0;
        for (int i = 0; i < r.ln; i++)
            if (durs[i] >= DASH) r.pat = r.pat + (1 << i);
        return r;
    endfunction

    task automatic send_letter(input int durs[$], input bit rand_ack);
        int lat;
        int g;
        exp_q.push_back(model(durs));
        for (int j = 0; j < durs.size(); j++) begin
            repeat (durs[j]) begin
                @(negedge clk);
                btn = 1'b1;
                ack = 1'b0;
            end
            if (j < durs.size() - 1) begin
                g = $urandom_range(1, LG - 1);
                repeat (g) begin
                    @(negedge clk);
                    btn = 1'b0;
                    ack = rand_ack && ($urandom_range(0, 3) == 0);
                end
            end
        end
        @(negedge clk);
        check("busy_in_letter", busy, 1);
        btn = 1'b0;
        ack = 1'b0;
        lat = 0;
        for (int i = 1; i <= LG + 8; i++) begin
            @(negedge clk);
            if (valid) begin
                lat = i;
                break;
            end
        end
        check("valid_latency", lat, LG);
        check("busy_done", busy, 0);
        repeat ($urandom_range(1, 20)) begin
            @(negedge clk);
            btn = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        btn = 1'b0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack_valid_clr", valid, 0);
        check("ack_len_clr", len, 0);
        check("ack_pattern_clr", pattern, 0);
        check("ack_overflow_clr", overflow, 0);
    endtask

    // Scoreboard monitor: pops an expected letter whenever valid rises.
    initial begin
        bit      prev_v;
        bit      stable;
        letter_t cur;
        prev_v = 1'b0;
        stable = 1'b1;
        cur = '{0, 0, 0};
        forever begin
            @(posedge clk);
            #1;
            if (valid === 1'b1 && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_letter", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("pattern", pattern, cur.pat);
                    check("len", len, cur.ln);
                    check("overflow", overflow, cur.ovf);
                    stable = 1'b1;
                end
            end else if (valid === 1'b1 && prev_v) begin
                if (pattern != cur.pat || len != cur.ln || overflow != cur.ovf) stable = 1'b0;
            end else if (prev_v) begin
                check("done_stable", stable, 1);
            end
            if (word_gap === 1'b1) wg_pulses++;
            prev_v = (valid === 1'b1);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1;
        btn   = 1'b0;
        ack   = 1'b0;
        #12;
        check("rst_valid", valid, 0);
        check("rst_len", len, 0);
        check("rst_pattern", pattern, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_word_gap", word_gap, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        d = {3};             send_letter(d, 1'b0);
        d = {10, 3, 8, 3};   send_letter(d, 1'b0);
        d = {7};             send_letter(d, 1'b0);
        d = {8};             send_letter(d, 1'b0);
        d = {3, 3, 3, 3, 3, 3}; send_letter(d, 1'b0);
        d = {259, 2};        send_letter(d, 1'b0);

        // Reset in the middle of the second press of a letter.
        repeat (3) begin @(negedge clk); btn = 1'b1; end
        repeat (4) begin @(negedge clk); btn = 1'b0; end
        repeat (3) begin @(negedge clk); btn = 1'b1; end
        check("pre_rst_len", len, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_len", len, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", valid, 0);
        check("async_rst_pattern", pattern, 0);
        @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        d = {3};             send_letter(d, 1'b0);

        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(1, 7);
            d = {};
            for (int i = 0; i < n; i++)
                d.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(7, 8)
                                                        : $urandom_range(1, 14));
            send_letter(d, 1'b1);
        end

`ifdef MORSE_WORD_GAP_EN
        d = {3};             send_letter(d, 1'b0);
        repeat (WG + 10) @(negedge clk);
        wg_expected++;
        d = {3};             send_letter(d, 1'b0);
        repeat (37) @(negedge clk);
        d = {3};             send_letter(d, 1'b0);
`endif

        repeat (5) @(negedge clk);
        check("letters_consumed", exp_q.size(), 0);
        check("word_gap_pulses", wg_pulses, wg_expected);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
